// File: rtl/frac_mult_sched_pkg.sv
// Shared types for the fraction-multiplier scheduler: FSM state encoding and default widths.
package frac_mult_sched_pkg;

  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } fms_state_e;

  localparam int DEF_W    = 4;
  localparam int DEF_NREQ = 4;

endpackage

// File: rtl/frac_mult_rr_pick.sv
// Combinational rotating-priority pick: first requester at or after ptr that is not excluded.
module frac_mult_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic [NREQ-1:0] excl,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] cand;
  logic [IW-1:0]   pos;

  // Walk offsets from far to near so the closest candidate to ptr wins last.
  always_comb begin
    cand  = req & ~excl;
    valid = |cand;
    idx   = '0;
    pos   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = IW'((int'(ptr) + k) % NREQ);
      if (cand[pos]) idx = pos;
    end
  end

endmodule

// File: rtl/frac_mult_sched.sv
// Round-robin scheduler sharing one St/Done fraction multiplier among NREQ requesters.
// Optional FMS_TIMEOUT_EN: abort a WAIT that sees no MulDone within TIMEOUT cycles.
module frac_mult_sched
  import frac_mult_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int DRAIN   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic [NREQ-1:0]   Req,
  input  logic [NREQ*W-1:0] ReqMplier,
  input  logic [NREQ*W-1:0] ReqMcand,
  output logic [NREQ-1:0]   RspAck,
  output logic [2*W-2:0]    RspProduct,
  output logic [2:0]        GntId,
  output logic              Busy,
  output logic              Err,
  output logic              MulSt,
  output logic [W-1:0]      MulMplier,
  output logic [W-1:0]      MulMcand,
  input  logic [2*W-2:0]    MulProduct,
  input  logic              MulDone
);

  localparam int IW   = $clog2(NREQ);
  localparam int CMAX = (DRAIN > TIMEOUT) ? DRAIN : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  fms_state_e      state, nxt;
  logic [IW-1:0]   ptr, gnt, gnt_inc, pick_ptr, win;
  logic [NREQ-1:0] excl;
  logic [CW-1:0]   cnt;
  logic            pick_vld, grant, drain_done, timeout;

  assign gnt_inc    = (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
  assign drain_done = (cnt == CW'(DRAIN - 1));

  // In RESP the pointer update is still in flight, so pick from its next value.
  assign pick_ptr = (state == S_RESP) ? gnt_inc : ptr;
  assign excl     = (state == S_RESP) ? (NREQ'(1) << gnt) : '0;

  frac_mult_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (Req),
    .ptr   (pick_ptr),
    .excl  (excl),
    .valid (pick_vld),
    .idx   (win)
  );

  assign grant = pick_vld && (state == S_IDLE || state == S_RESP);

`ifdef FMS_TIMEOUT_EN
  assign timeout = (state == S_WAIT) && !MulDone && (cnt == CW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_DRAIN: if (drain_done) nxt = S_IDLE;
      S_IDLE:  if (pick_vld) nxt = S_START;
      S_START: nxt = S_WAIT;
      S_WAIT: begin
        if (MulDone)      nxt = S_RESP;
        else if (timeout) nxt = S_DRAIN;
      end
      S_RESP:  nxt = pick_vld ? S_START : S_IDLE;
      default: nxt = S_DRAIN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state      <= S_DRAIN;
      cnt        <= '0;
      ptr        <= '0;
      gnt        <= '0;
      MulMplier  <= '0;
      MulMcand   <= '0;
      RspProduct <= '0;
      Err        <= 1'b0;
    end else begin
      state <= nxt;
      Err   <= timeout;
      if (state != nxt)                           cnt <= '0;
      else if (state == S_DRAIN || state == S_WAIT) cnt <= cnt + CW'(1);
      if (grant) begin
        gnt       <= win;
        MulMplier <= ReqMplier[win*W +: W];
        MulMcand  <= ReqMcand[win*W +: W];
      end
      if (state == S_RESP || timeout) ptr <= gnt_inc;
      if (state == S_WAIT && MulDone) RspProduct <= MulProduct;
    end
  end

  assign MulSt  = (state == S_START);
  assign Busy   = (state != S_IDLE);
  assign RspAck = (state == S_RESP) ? (NREQ'(1) << gnt) : '0;
  assign GntId  = 3'(gnt);

endmodule

// File: tb/tb_frac_mult_sched.sv
// Scoreboard bench for frac_mult_sched with a 5-cycle St/Done fraction multiplier model.
module tb_frac_mult_sched;

  localparam int NREQ = 4;
  localparam int W    = 4;
`ifdef FMS_TIMEOUT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic            CLK;
  logic            Rst;
  logic [NREQ-1:0] Req;
  logic [NREQ*W-1:0] ReqMplier, ReqMcand;
  logic [NREQ-1:0] RspAck;
  logic [2*W-2:0]  RspProduct;
  logic [2:0]      GntId;
  logic            Busy, Err, MulSt;
  logic [W-1:0]    MulMplier, MulMcand;
  logic [2*W-2:0]  MulProduct;
  logic            MulDone;

  frac_mult_sched #(.NREQ(NREQ), .W(W), .DRAIN(6), .TIMEOUT(15)) dut (
    .CLK(CLK), .Rst(Rst), .Req(Req), .ReqMplier(ReqMplier), .ReqMcand(ReqMcand),
    .RspAck(RspAck), .RspProduct(RspProduct), .GntId(GntId), .Busy(Busy), .Err(Err),
    .MulSt(MulSt), .MulMplier(MulMplier), .MulMcand(MulMcand),
    .MulProduct(MulProduct), .MulDone(MulDone)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc;
  always @(posedge CLK) cyc <= cyc + 1;

  // Multiplier model: product of live operands at St, Done five cycles later; kill suppresses Done.
  logic kill;
  int   mcnt;
  function automatic logic [6:0] prod7(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] f;
    f = $signed(a) * $signed(b);
    return f[6:0];
  endfunction
  always @(posedge CLK) begin
    if (MulSt) begin
      mcnt       <= 4;
      MulProduct <= prod7(MulMplier, MulMcand);
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
    MulDone <= (mcnt == 1) && !kill;
  end

  typedef struct {
    logic [3:0] ack;
    logic [6:0] prod;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp, n_bad, st_cnt, err_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] ack, input logic [6:0] prod, input int at);
    exp_t e;
    e.ack  = ack;
    e.prod = prod;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (MulSt) st_cnt++;
      if (Err) err_cnt++;
      if (|RspAck) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack %b product %b with none outstanding", RspAck, RspProduct);
        end else begin
          e = exp_q.pop_front();
          chk("ack", 32'(RspAck), 32'(e.ack));
          chk("product", 32'(RspProduct), 32'(e.prod));
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  // One cycle; a requester drops its Req right after seeing its own RspAck.
  task automatic tick();
    logic [NREQ-1:0] a;
    @(negedge CLK);
    a = RspAck;
    @(posedge CLK);
    #1;
    Req = Req & ~a;
  endtask

  task automatic issue(input int i, input logic [3:0] mp, input logic [3:0] mc);
    ReqMplier[i*W +: W] = mp;
    ReqMcand[i*W +: W]  = mc;
    Req[i]              = 1'b1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ack", 32'(RspAck), 0);
    chk("rst_product", 32'(RspProduct), 0);
    chk("rst_gnt", 32'(GntId), 0);
    chk("rst_mulst", 32'(MulSt), 0);
    chk("rst_mplier", 32'(MulMplier), 0);
    chk("rst_mcand", 32'(MulMcand), 0);
    chk("rst_err", 32'(Err), 0);
    chk("rst_busy", 32'(Busy), 1);
  endtask

  int c, s0;

  initial begin
    Rst = 1'b1; Req = '0; ReqMplier = '0; ReqMcand = '0; kill = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) begin @(posedge CLK); #1; end
    @(negedge CLK);
    chk_reset_outputs();
    @(posedge CLK); #1;

    // Release reset with Req[0] already up: it must wait out the drain.
    Rst = 1'b0;
    c = cyc;
    issue(0, 4'b0011, 4'b0100);
    push(4'b0001, 7'b0001100, c + 13);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("drain_busy", 32'(Busy), 1);
      chk("drain_no_st", 32'(MulSt), 0);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    chk("idle_busy", 32'(Busy), 0);
    @(posedge CLK); #1;
    repeat (9) tick();

    // 0.75 * 0.625
    c = cyc;
    issue(1, 4'b0110, 4'b0101);
    push(4'b0010, 7'b0011110, c + 7);
    repeat (10) tick();

    // -0.75 * 0.75; Req dropped and operands changed after grant
    c = cyc;
    s0 = st_cnt;
    issue(2, 4'b1010, 4'b0110);
    push(4'b0100, 7'b1011100, c + 7);
    repeat (2) tick();
    ReqMplier[2*W +: W] = 4'b0111;
    Req[2] = 1'b0;
    repeat (2) tick();
    @(negedge CLK);
    chk("held_mplier", 32'(MulMplier), 32'(4'b1010));
    chk("held_mcand", 32'(MulMcand), 32'(4'b0110));
    @(posedge CLK); #1;
    repeat (6) tick();
    chk("one_st_pulse", 32'(st_cnt - s0), 1);

    // 0.5 * -0.5, moves pointer from 3 around to 0
    c = cyc;
    issue(3, 4'b0100, 4'b1100);
    push(4'b1000, 7'b1110000, c + 7);
    repeat (10) tick();

    // All four at once: served 0,1,2,3 back-to-back every 7 cycles
    c = cyc;
    issue(0, 4'b0111, 4'b0111);
    issue(1, 4'b1000, 4'b0100);
    issue(2, 4'b1111, 4'b1111);
    issue(3, 4'b0101, 4'b1011);
    push(4'b0001, 7'b0110001, c + 7);
    push(4'b0010, 7'b1100000, c + 14);
    push(4'b0100, 7'b0000001, c + 21);
    push(4'b1000, 7'b1100111, c + 28);
    repeat (32) tick();
    @(negedge CLK);
    chk("last_gnt", 32'(GntId), 3);
    @(posedge CLK); #1;

    // Pointer wrapped to 0: requester 1 goes ahead of 3
    c = cyc;
    Req = 4'b1010;
    push(4'b0010, 7'b1100000, c + 7);
    push(4'b1000, 7'b1100111, c + 14);
    repeat (18) tick();

    // Reset mid-WAIT, then a fresh request after the drain
    c = cyc;
    issue(1, 4'b0110, 4'b0101);
    repeat (3) tick();
    Rst = 1'b1;
    Req = '0;
    tick();
    @(negedge CLK);
    chk_reset_outputs();
    @(posedge CLK); #1;
    Rst = 1'b0;
    c = cyc;
    issue(3, 4'b0011, 4'b1101);
    push(4'b1000, 7'b1110111, c + 13);
    repeat (16) tick();

`ifdef FMS_TIMEOUT_EN
    kill = 1'b1;
    c = cyc;
    issue(0, 4'b0111, 4'b0001);
    repeat (16) tick();
    @(negedge CLK);
    chk("err_before", 32'(Err), 0);
    @(posedge CLK); #1;
    Req = '0;
    @(negedge CLK);
    chk("err_pulse", 32'(Err), 1);
    chk("busy_after_timeout", 32'(Busy), 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("err_clear", 32'(Err), 0);
    @(posedge CLK); #1;
    kill = 1'b0;
    repeat (6) tick();
    c = cyc;
    issue(0, 4'b0111, 4'b0001);
    push(4'b0001, 7'b0000111, c + 7);
    repeat (10) tick();
`endif

    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("err_pulses", 32'(err_cnt), 32'(EXP_ERR));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
